// File: rtl/spi_master_ctrl_if.sv
// Command/response bundle for the SPI master sequencer.
//   master modport : the command issuer (drives req_*, div; sees ready/done/rx)
//   slave modport  : the sequencer itself
// Signals:
//   req_valid/req_ready : command handshake, accepted when both are high
//   req_tx, req_len     : transmit word and bit count (0 or >DATA_W means DATA_W)
//   req_ss              : one-hot slave select for the transfer
//   div                 : sck half-period is div+1 clk cycles
//   done, rx_data       : completion pulse and received word
//   busy                : inverse of req_ready
interface spi_master_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int NSS    = 8,
    parameter int DIV_W  = 8
);
    localparam int LEN_W = $clog2(DATA_W) + 1;

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_tx;
    logic [LEN_W-1:0]  req_len;
    logic [NSS-1:0]    req_ss;
    logic [DIV_W-1:0]  div;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              busy;

    modport master (
        output req_valid, req_tx, req_len, req_ss, div,
        input  req_ready, done, rx_data, busy
    );

    modport slave (
        input  req_valid, req_tx, req_len, req_ss, div,
        output req_ready, done, rx_data, busy
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master sequencer: takes one command, runs one full-duplex
// transfer (setup, len bit periods, hold), returns the received bits.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : command/response bundle (slave modport)
//   sck        : SPI clock, idles low
//   ss_n       : active-low slave selects
//   mosi       : master out, changes only while sck is low, idles high
//   miso       : master in, sampled on each sck falling edge
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | ready for a command, bus idle; first cycle after HOLD = done
// S_SETUP    | ss asserted, first bit on mosi, sck low for H cycles
// S_SHIFT_HI | sck high for H cycles, slave samples on entry
// S_SHIFT_LO | sck low for H cycles, master sampled miso on entry
// S_HOLD     | sck low, ss still asserted for H cycles after last bit
module spi_master_ctrl #(
    parameter int DATA_W = 16,
    parameter int NSS    = 8,
    parameter int DIV_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_master_ctrl_if.slave   bus,
    output logic               sck,
    output logic [NSS-1:0]     ss_n,
    output logic               mosi,
    input  logic               miso
);
    localparam int LEN_W = $clog2(DATA_W) + 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT_HI,
        S_SHIFT_LO,
        S_HOLD
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // One bit wider than div so a div of all-ones never wraps.
    logic [DIV_W:0]    hcnt;
    logic [DIV_W-1:0]  div_lat;
    logic [LEN_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_lat;
    logic [DATA_W-1:0] rx_sh;
    logic [NSS-1:0]    ss_lat;
    logic              done_q;
    logic [DATA_W-1:0] rx_data_q;

    logic              accept;
    logic              phase_end;
    logic [LEN_W-1:0]  len_eff;
    logic [IDX_W-1:0]  bit_idx;

    assign accept    = bus.req_valid && (state == S_IDLE);
    assign phase_end = (hcnt == '0);
    assign len_eff   = ((bus.req_len == '0) || (bus.req_len > LEN_W'(DATA_W)))
                       ? LEN_W'(DATA_W) : bus.req_len;
    // bit_cnt counts bits not yet sampled; the bit on the wire is bit_cnt-1.
    assign bit_idx   = IDX_W'(bit_cnt - LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (bus.req_valid) state_nxt = S_SETUP;
            S_SETUP:    if (phase_end)     state_nxt = S_SHIFT_HI;
            S_SHIFT_HI: if (phase_end)     state_nxt = S_SHIFT_LO;
            S_SHIFT_LO: if (phase_end)     state_nxt = (bit_cnt == '0) ? S_HOLD : S_SHIFT_HI;
            S_HOLD:     if (phase_end)     state_nxt = S_IDLE;
            default:                       state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt      <= '0;
            div_lat   <= '0;
            bit_cnt   <= '0;
            tx_lat    <= '0;
            rx_sh     <= '0;
            ss_lat    <= '0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                tx_lat  <= bus.req_tx;
                bit_cnt <= len_eff;
                ss_lat  <= bus.req_ss;
                div_lat <= bus.div;
                hcnt    <= {1'b0, bus.div};
                rx_sh   <= '0;
            end else if (state != S_IDLE) begin
                if (phase_end) begin
                    hcnt <= {1'b0, div_lat};
                    // Leaving SHIFT_HI is the sck falling edge: capture miso.
                    if (state == S_SHIFT_HI) begin
                        rx_sh   <= {rx_sh[DATA_W-2:0], miso};
                        bit_cnt <= bit_cnt - LEN_W'(1);
                    end
                    if (state == S_HOLD) begin
                        done_q    <= 1'b1;
                        rx_data_q <= rx_sh;
                    end
                end else begin
                    hcnt <= hcnt - (DIV_W+1)'(1);
                end
            end
        end
    end

    always_comb begin
        sck  = (state == S_SHIFT_HI);
        ss_n = (state == S_IDLE) ? {NSS{1'b1}} : ~ss_lat;
        mosi = 1'b1;
        if (((state == S_SETUP) || (state == S_SHIFT_HI) || (state == S_SHIFT_LO))
            && (bit_cnt != '0)) begin
            mosi = tx_lat[bit_idx];
        end
    end

    assign bus.req_ready = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_q;
    assign bus.rx_data   = rx_data_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
`timescale 1ns/1ps
module tb_spi_master_ctrl;
    localparam int DATA_W = 16;
    localparam int NSS    = 8;
    localparam int DIV_W  = 8;
    localparam int LEN_W  = $clog2(DATA_W) + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sck;
    logic [NSS-1:0] ss_n;
    logic           mosi;
    logic           miso;
    logic           miso_s = 1'b1;
    int             mode = 0;   // 0 loopback, 1 byte-echo slave, 2 miso held low

    spi_master_ctrl_if #(.DATA_W(DATA_W), .NSS(NSS), .DIV_W(DIV_W)) bus ();

    spi_master_ctrl #(.DATA_W(DATA_W), .NSS(NSS), .DIV_W(DIV_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .sck   (sck),
        .ss_n  (ss_n),
        .mosi  (mosi),
        .miso  (miso)
    );

    always #5 clk = ~clk;

    assign miso = (mode == 0) ? mosi : (mode == 1) ? miso_s : 1'b0;

    // Slave: shifts in 8 bits on rising edges while driving 1, then echoes
    // the captured byte MSB-first, updating on rising edges 9..16.
    int       sl_cnt = 0;
    logic [7:0] sl_sh = '0;
    always @(posedge sck) begin
        sl_cnt = sl_cnt + 1;
        if (sl_cnt <= 8) begin
            sl_sh  = {sl_sh[6:0], mosi};
            miso_s = 1'b1;
        end else if (sl_cnt <= 16) begin
            miso_s = sl_sh[16 - sl_cnt];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [DATA_W-1:0] tx;
        int                len;
        logic [NSS-1:0]    ss;
        int                h;
        logic [DATA_W-1:0] rx;
        int                tcmd;
    } exp_t;

    exp_t sb[$];

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Monitor: measures each transfer on the negedge and scores it at done.
    int   rises = 0, ph_err = 0, ss_low = 0, ss_bad = 0, mosi_err = 0;
    int   hi_run = 0, lo_run = 0, done_cnt = 0, last_done = -1;
    logic sck_prev = 1'b0;
    exp_t cur;

    task automatic clear_meas();
        rises = 0; ph_err = 0; ss_low = 0; ss_bad = 0; mosi_err = 0;
        hi_run = 0; lo_run = 0; sck_prev = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            clear_meas();
        end else if (bus.done) begin
            done_cnt++;
            last_done = cyc;
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                cur = sb.pop_front();
                chk("rx_data", bus.rx_data, cur.rx);
                chk("latency", cyc - cur.tcmd, (2 * cur.len + 2) * cur.h + 1);
                chk("sck_rises", rises, cur.len);
                chk("phase_len_err", ph_err, 0);
                chk("tail_low", lo_run, 2 * cur.h);
                chk("ss_low_cycles", ss_low, (2 * cur.len + 2) * cur.h);
                chk("ss_value_err", ss_bad, 0);
                chk("mosi_err", mosi_err, 0);
                chk("ss_n_at_done", ss_n, {NSS{1'b1}});
                chk("ready_at_done", bus.req_ready, 1);
            end
            clear_meas();
        end else if (sb.size() > 0) begin
            cur = sb[0];
            if (sck && !sck_prev) begin
                int idx;
                rises++;
                if (lo_run != cur.h) ph_err++;
                lo_run = 0;
                idx = cur.len - rises;
                if (idx < 0 || idx >= DATA_W) mosi_err++;
                else if (mosi !== cur.tx[idx]) mosi_err++;
            end
            if (!sck && sck_prev) begin
                if (hi_run != cur.h) ph_err++;
                hi_run = 0;
            end
            if (sck) hi_run++;
            else if (ss_n != {NSS{1'b1}}) lo_run++;
            if (ss_n != {NSS{1'b1}}) begin
                ss_low++;
                if (ss_n !== ~cur.ss) ss_bad++;
            end
            sck_prev = sck;
        end
    end

    task automatic send(input logic [DATA_W-1:0] tx, input int len, input logic [NSS-1:0] ss,
                        input int dv, input logic [DATA_W-1:0] rx, input bit keep,
                        output int tcmd);
        exp_t e;
        bit   ok;
        @(negedge clk); #2;
        bus.req_tx    = tx;
        bus.req_len   = LEN_W'(len);
        bus.req_ss    = ss;
        bus.div       = DIV_W'(dv);
        bus.req_valid = 1'b1;
        ok   = 1'b0;
        tcmd = -1;
        for (int n = 0; n < 5000; n++) begin
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #2;
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            bus.req_valid = 1'b0;
            return;
        end
        tcmd   = cyc;
        e.tx   = tx;
        e.len  = (len == 0 || len > DATA_W) ? DATA_W : len;
        e.ss   = ss;
        e.h    = dv + 1;
        e.rx   = rx;
        e.tcmd = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 5000 && sb.size() != 0; n++) @(negedge clk);
        chk("wait_done_timeout", sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    int t_a, t_b, dc;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_tx    = '0;
        bus.req_len   = '0;
        bus.req_ss    = '0;
        bus.div       = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_sck", sck, 0);
        chk("rst_ss_n", ss_n, 8'hFF);
        chk("rst_mosi", mosi, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_rx", bus.rx_data, 0);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_busy", bus.busy, 0);

        // Loopback, full width, fastest clock.
        mode = 0;
        send(16'hA5C3, 16, 8'h01, 0, 16'hA5C3, 1'b0, t_a);
        wait_idle();

        // Byte-echo slave.
        mode = 1; sl_cnt = 0;
        send(16'h3500, 16, 8'h01, 1, 16'hFF35, 1'b0, t_a);
        wait_idle();

        // Single bit, slow clock, top slave select, miso low.
        mode = 2;
        send(16'h0001, 1, 8'h80, 3, 16'h0000, 1'b0, t_a);
        wait_idle();

        // len=0 means full width; valid held so the next command lands on done.
        mode = 0;
        send(16'hFFFF, 0, 8'h04, 0, 16'hFFFF, 1'b1, t_a);
        send(16'h00F0, 8, 8'h08, 0, 16'h00F0, 1'b0, t_b);
        chk("b2b_accept_cycle", t_b, last_done);
        chk("ss_after_gap", ss_n, 8'hF7);
        wait_idle();

        // Inputs changing mid-transfer must not disturb it.
        send(16'h1234, 12, 8'h10, 2, 16'h0234, 1'b0, t_a);
        repeat (10) @(negedge clk);
        #2;
        bus.div     = 8'd7;
        bus.req_tx  = 16'hFFFF;
        bus.req_ss  = 8'h01;
        bus.req_len = LEN_W'(3);
        chk("busy_mid", bus.busy, 1);
        chk("ready_mid", bus.req_ready, 0);
        wait_idle();

        // Reset in the 5th sck pulse.
        send(16'hBEEF, 16, 8'h20, 1, 16'hBEEF, 1'b0, t_a);
        for (int n = 0; n < 500 && rises < 5; n++) begin
            @(negedge clk); #1;
        end
        chk("reached_pulse5", rises, 5);
        chk("pulse5_sck_high", sck, 1);
        dc = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("arst_sck", sck, 0);
        chk("arst_ss_n", ss_n, 8'hFF);
        chk("arst_mosi", mosi, 1);
        chk("arst_done", bus.done, 0);
        chk("arst_rx", bus.rx_data, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("no_done_after_rst", done_cnt, dc);
        chk("ready_after_rst", bus.req_ready, 1);
        send(16'h5A5A, 16, 8'h40, 0, 16'h5A5A, 1'b0, t_a);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
